// File: rtl/ra_stack.sv
// Return-address stack for the instruction-fetch stage.
// Calls push the current fetch pointer; returns read the top entry
// combinationally and pop it on the same clock edge. Overflow wraps
// circularly and silently overwrites the oldest entry.
module ra_stack #(
  parameter int AW    = 14,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [AW-1:0] npc,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] ra,
  output logic          empty,
  output logic          full
);

  // Pointer width indexes the circular array; the count needs one more bit
  // so that it can hold the value DEPTH itself.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW-1:0] sp_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [PW-1:0] top_s;
  logic          empty_s;
  logic          full_s;

  // Top index and occupancy flags, all derived from registered state only.
  always_comb begin
    top_s   = sp_q - PW'(1);
    empty_s = (cnt_q == CW'(0));
    full_s  = (cnt_q == CW'(DEPTH));
  end

  // Next-state computation for the entry array, pointer and count.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (stall) begin
      mem_d = mem_q;
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end else begin
      case ({push, pop})
        2'b10: begin
          // Push: a full stack keeps its count while the oldest slot is reused.
          mem_d[sp_q] = npc;
          sp_d        = sp_q + PW'(1);
          if (full_s) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        2'b01: begin
          // Pop: ignored on an empty stack; the popped slot keeps its value.
          if (empty_s) begin
            sp_d  = sp_q;
            cnt_d = cnt_q;
          end else begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        2'b11: begin
          // Push and pop together replace the top entry; on an empty stack
          // there is no top, so it degenerates into a plain push.
          if (empty_s) begin
            mem_d[sp_q] = npc;
            sp_d        = sp_q + PW'(1);
            cnt_d       = cnt_q + CW'(1);
          end else begin
            mem_d[top_s] = npc;
            sp_d         = sp_q;
            cnt_d        = cnt_q;
          end
        end
        default: begin
          sp_d  = sp_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output drive: top entry when the stack holds anything, zero otherwise.
  always_comb begin
    if (empty_s) begin
      ra = '0;
    end else begin
      ra = mem_q[top_s];
    end
    empty = empty_s;
    full  = full_s;
  end

endmodule

// File: tb/tb_ra_stack.sv
// Self-checking bench for ra_stack: a queue-based model of the stack is
// compared against the DUT every cycle, with directed scenarios pinned by
// literal expectations followed by randomized traffic.
module tb_ra_stack;

  localparam int AW    = 14;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [AW-1:0] npc = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] ra;
  logic          empty;
  logic          full;

  int checks   = 0;
  int failures = 0;

  // Model: newest entry at the back; at most DEPTH entries kept.
  logic [AW-1:0] model_q[$];
  bit            model_valid = 1'b0;

  ra_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .npc   (npc),
    .push  (push),
    .pop   (pop),
    .ra    (ra),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] model_ra();
    if (model_q.size() > 0) return model_q[$];
    return '0;
  endfunction

  // Model update from the stack's rules, on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      model_valid = 1'b1;
    end else if (model_valid && !stall) begin
      if (push && pop && model_q.size() > 0) begin
        model_q[model_q.size()-1] = npc;
      end else if (push) begin
        model_q.push_back(npc);
        if (model_q.size() > DEPTH) void'(model_q.pop_front());
      end else if (pop) begin
        if (model_q.size() > 0) void'(model_q.pop_back());
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("ra_vs_model", 32'(ra), 32'(model_ra()));
      chk("empty_vs_model", 32'(empty), 32'(model_q.size() == 0));
      chk("full_vs_model", 32'(full), 32'(model_q.size() == DEPTH));
    end
  end

  task automatic cyc(input bit r, input bit s, input bit pu, input bit po,
                     input logic [AW-1:0] a);
    rst   = r;
    stall = s;
    push  = pu;
    pop   = po;
    npc   = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 14'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
    chk("reset_ra", 32'(ra), 32'h0);
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_full", 32'(full), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("underflow_ra", 32'(ra), 32'h0);
    chk("underflow_empty", 32'(empty), 32'h1);

    // Three pushes then three pops.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h0010);
    chk("push1_ra", 32'(ra), 32'h0010);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h0123);
    chk("push2_ra", 32'(ra), 32'h0123);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h3FFF);
    chk("push3_ra", 32'(ra), 32'h3FFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("pop1_ra", 32'(ra), 32'h0123);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("pop2_ra", 32'(ra), 32'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("pop3_ra", 32'(ra), 32'h0);
    chk("pop3_empty", 32'(empty), 32'h1);

    // Stalled push is ignored, unstalled push lands.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 14'h0005);
    chk("stall_ra", 32'(ra), 32'h0);
    chk("stall_empty", 32'(empty), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h0005);
    chk("unstall_ra", 32'(ra), 32'h0005);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("unstall_pop_empty", 32'(empty), 32'h1);

    // Overflow: push 1..17, oldest value is lost.
    for (int v = 1; v <= 17; v++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'(v));
      if (v == 15) chk("full_before_16", 32'(full), 32'h0);
      if (v == 16) chk("full_at_16", 32'(full), 32'h1);
    end
    chk("overflow_ra", 32'(ra), 32'd17);
    chk("overflow_full", 32'(full), 32'h1);
    for (int k = 0; k < 16; k++) begin
      chk("overflow_pop_ra", 32'(ra), 32'(17 - k));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    end
    chk("overflow_drain_empty", 32'(empty), 32'h1);
    chk("overflow_drain_ra", 32'(ra), 32'h0);

    // Replace-top with simultaneous push and pop.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h0100);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 14'h0200);
    chk("replace_ra", 32'(ra), 32'h0200);
    chk("replace_empty", 32'(empty), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 14'h0000);
    chk("replace_pop_empty", 32'(empty), 32'h1);

    // Push and pop together on an empty stack acts as a push.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 14'h0777);
    chk("pushpop_empty_ra", 32'(ra), 32'h0777);

    // Reset wins over a simultaneous push.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 14'h0AAA);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 14'h0BBB);
    chk("rst_push_ra", 32'(ra), 32'h0);
    chk("rst_push_empty", 32'(empty), 32'h1);

    // Randomized traffic in push-heavy, pop-heavy and balanced phases.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      int pp;
      bit r;
      bit s;
      bit pu;
      bit po;
      ph = (i / 150) % 3;
      pp = (ph == 0) ? 80 : ((ph == 1) ? 20 : 50);
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 7) == 0);
      pu = ($urandom_range(0, 99) < pp);
      po = ($urandom_range(0, 99) < (100 - pp));
      cyc(r, s, pu, po, 14'($urandom));
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
